spi_slave_ram_burst: RTL and testbench
======================================

Name: spi_slave_ram_burst

Overview:
- Parametrised SPI slave with an integrated single-port RAM. It is the next generation of the fixed 8-bit SPI slave/RAM wrapper.
- Generalises address and data width and memory depth.
- Adds burst streaming: multiple data words per ss_n frame, with address auto-increment and wrap.
- Sits behind the chip-level SPI pins. One system clock samples MOSI directly; no separate SCK domain.

Parameters:
- ADDR_W, 8, address width in bits.
- DATA_W, 8, data word width in bits.
- MEM_DEPTH, 256, number of RAM words; must satisfy 2 <= MEM_DEPTH <= 2**ADDR_W.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst_n  input  1  reset; synchronous, active-low.
- ss_n  input  1  slave select, active-low; frames a transaction.
- MOSI  input  1  serial data in, MSB first, sampled on the clk rising edge.
- MISO  output  1  serial data out, MSB first.

Behaviour:
- Clocking and reset: one clock (clk). Reset is synchronous and active-low (rst_n). Reset takes priority over every other event.
- Reset values:
  - state = IDLE; wr_addr = 0; rd_addr = 0; shift register = 0; bit counter = 0; MISO = 0.
  - RAM contents are not reset.
- States: IDLE, CMD, WR_ADDR, WR_DATA, RD_ADDR, RD_LOAD, RD_SHIFT.
- IDLE: MISO = 0. ss_n sampled 0 -> CMD. The MOSI value on that edge is ignored.
- CMD: two edges capture cmd[1:0], MSB first.
  - 00 -> WR_ADDR
  - 01 -> WR_DATA
  - 10 -> RD_ADDR
  - 11 -> RD_LOAD
- WR_ADDR: shift ADDR_W bits. On the last bit, wr_addr is loaded -> IDLE-wait: state holds and ignores MOSI until ss_n rises.
- WR_DATA: shift DATA_W bits. On the last bit:
  - mem[wr_addr] <= word, if wr_addr < MEM_DEPTH; otherwise the write is dropped.
  - wr_addr <= next(wr_addr).
  - The bit counter clears and the state stays in WR_DATA for the next word.
- RD_ADDR: shift ADDR_W bits. On the last bit, rd_addr is loaded -> IDLE-wait.
- RD_LOAD (1 cycle):
  - shift register <= mem[rd_addr], or 0 if rd_addr >= MEM_DEPTH.
  - rd_addr <= next(rd_addr).
  - MISO = 0.
  - -> RD_SHIFT.
- RD_SHIFT (DATA_W cycles): MISO = shift register MSB, left shift each cycle. After the last bit -> RD_LOAD.
  - Each read word therefore takes DATA_W+1 cycles, including one dead cycle with MISO = 0.
  - MOSI is ignored during reads.
- MISO is driven from registers only and is 0 in every state other than RD_SHIFT.
- next(a) = 0 if a == MEM_DEPTH-1, else a+1, truncated to ADDR_W.
- ss_n high, sampled in any non-IDLE state -> IDLE on that edge.
  - The partial word is discarded and nothing is written.
  - Addresses keep their last committed values.
- Latency: the first read bit appears on MISO 2 edges after the last cmd bit is sampled (the RD_LOAD cycle, then RD_SHIFT).
- rst_n low mid-frame: state returns to IDLE on that edge. Traffic resumes only after ss_n is high for at least 1 cycle, then falls again.
- Read-after-write to the same address in a later frame returns the new data. No same-cycle read/write conflict can occur (one operation per frame).

Optional Feature:
- Macro SPI_SLAVE_BURST_EN.
- Defined: streaming as described. WR_DATA and RD_SHIFT loop while ss_n stays low, and addresses auto-increment.
- Not defined:
  - One word per frame. After the first data word, the FSM enters IDLE-wait.
  - wr_addr and rd_addr are never incremented.
  - Extra MOSI bits are ignored and MISO stays 0 until ss_n rises.

Test Plan (ADDR_W=8, DATA_W=8, MEM_DEPTH=256, burst enabled unless noted):
- rst_n=0 for 2 edges with ss_n=0 and MOSI toggling -> MISO=0; a following read-data frame returns mem[0x00].
- Write addr 0x77, write data 0xAA, read addr 0x77, read data -> MISO shows 1,0,1,0,1,0,1,0 starting 2 edges after the last cmd bit.
- Burst write at 0xFE of 0x11, 0x22, 0x33 in one frame -> mem[FE]=11, mem[FF]=22, mem[00]=33 (wrap). A burst read from 0xFE returns 11, 22, 33, each word preceded by one MISO=0 cycle.
- Write addr 0x10, then a write-data frame with ss_n raised after 5 data bits -> mem[0x10] unchanged and wr_addr still 0x10. A full frame with 0x5C then writes mem[0x10]=0x5C.
- rst_n=0 during the 4th bit of a read word -> MISO=0 on that edge, state IDLE, rd_addr=0, RAM contents preserved.
- SPI_SLAVE_BURST_EN undefined: one write-data frame carrying 0x11 then 0x22 at addr 0x20 -> mem[0x20]=0x11, mem[0x21] untouched, wr_addr stays 0x20.

Source files
------------

// File: rtl/spi_slave_ram_burst.sv
// SPI slave (system-clock sampled) with an integrated single-port RAM and address/data framing.
// Define SPI_SLAVE_BURST_EN for multi-word streaming with address auto-increment; otherwise one word per frame.
module spi_slave_ram_burst #(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 8,
    parameter int MEM_DEPTH = 256
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ss_n,
    input  logic MOSI,
    output logic MISO
);
    localparam int SR_W  = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
    localparam int CNT_W = $clog2(SR_W + 1);
    localparam logic [CNT_W-1:0]  ADDR_LAST = CNT_W'(ADDR_W - 1);
    localparam logic [CNT_W-1:0]  DATA_LAST = CNT_W'(DATA_W - 1);
    localparam logic [ADDR_W-1:0] ADDR_TOP  = ADDR_W'(MEM_DEPTH - 1);
`ifdef SPI_SLAVE_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    // HOLD is the idle-wait state: frame is finished, ignore MOSI until ss_n rises.
    typedef enum logic [2:0] {IDLE, CMD, WR_ADDR, WR_DATA, RD_ADDR, RD_LOAD, RD_SHIFT, HOLD} state_t;

    state_t            state, state_nx;
    logic [ADDR_W-1:0] wr_addr, rd_addr;
    logic [SR_W-1:0]   sr;
    logic [CNT_W-1:0]  cnt;
    logic              armed;
    logic [DATA_W-1:0] mem [MEM_DEPTH];
    logic [DATA_W-1:0] rd_word, wr_word;
    logic [ADDR_W-1:0] addr_in;
    logic              addr_done, data_done, we;

    function automatic logic [ADDR_W-1:0] nxt(input logic [ADDR_W-1:0] a);
        return (a == ADDR_TOP) ? '0 : a + 1'b1;
    endfunction

    assign addr_in   = {sr[ADDR_W-2:0], MOSI};
    assign wr_word   = {sr[DATA_W-2:0], MOSI};
    assign addr_done = !ss_n && cnt == ADDR_LAST;
    assign data_done = !ss_n && cnt == DATA_LAST;
    assign we        = state == WR_DATA && data_done && int'(wr_addr) < MEM_DEPTH;

    always_comb begin
        rd_word = '0;
        if (int'(rd_addr) < MEM_DEPTH) rd_word = mem[rd_addr];
    end

    always_comb begin
        state_nx = state;
        if (state != IDLE && ss_n) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE: if (!ss_n && armed) state_nx = CMD;
                CMD: begin
                    if (cnt == CNT_W'(1)) begin
                        case ({sr[0], MOSI})
                            2'b00:   state_nx = WR_ADDR;
                            2'b01:   state_nx = WR_DATA;
                            2'b10:   state_nx = RD_ADDR;
                            default: state_nx = RD_LOAD;
                        endcase
                    end
                end
                WR_ADDR, RD_ADDR: if (cnt == ADDR_LAST) state_nx = HOLD;
                WR_DATA:  if (cnt == DATA_LAST && !BURST) state_nx = HOLD;
                RD_LOAD:  state_nx = RD_SHIFT;
                RD_SHIFT: if (cnt == DATA_LAST) state_nx = BURST ? RD_LOAD : HOLD;
                default:  ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_addr <= '0;
            rd_addr <= '0;
            sr      <= '0;
            cnt     <= '0;
            MISO    <= 1'b0;
            armed   <= 1'b0;
        end else begin
            // After reset a frame may only start once ss_n has been seen high.
            armed <= armed | ss_n;
            MISO  <= (state == RD_SHIFT && !ss_n) ? sr[DATA_W-1] : 1'b0;

            if (state_nx != state || state == IDLE || state == HOLD ||
                (state == WR_DATA && cnt == DATA_LAST))
                cnt <= '0;
            else
                cnt <= cnt + 1'b1;

            case (state)
                CMD, WR_ADDR, WR_DATA, RD_ADDR: sr <= {sr[SR_W-2:0], MOSI};
                RD_LOAD:  sr <= SR_W'(rd_word);
                RD_SHIFT: sr <= sr << 1;
                default:  ;
            endcase

            if (state == WR_ADDR && addr_done) wr_addr <= addr_in;
            if (state == RD_ADDR && addr_done) rd_addr <= addr_in;
            if (BURST && state == WR_DATA && data_done) wr_addr <= nxt(wr_addr);
            if (BURST && state == RD_LOAD && !ss_n)     rd_addr <= nxt(rd_addr);
        end
    end

    // RAM contents survive reset; writes are simply suppressed while it is held.
    always_ff @(posedge clk) begin
        if (rst_n && we) mem[wr_addr] <= wr_word;
    end
endmodule

// File: tb/tb_spi_slave_ram_burst.sv
// Randomized bench for spi_slave_ram_burst against a word-level memory/address model.
// Follows SPI_SLAVE_BURST_EN the same way the design does.
module tb_spi_slave_ram_burst;
    localparam int AW = 8, DW = 8, DEPTH = 256;
`ifdef SPI_SLAVE_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif
    typedef bit bq_t[$];
    typedef logic [DW-1:0] wq_t[$];

    logic clk = 1'b0, rst_n, ss_n, MOSI, MISO;
    int   errs = 0, checks = 0;
    logic [DW-1:0] mdl_mem [DEPTH];
    int   mdl_wa = 0, mdl_ra = 0;

    always #5 clk = ~clk;

    spi_slave_ram_burst #(.ADDR_W(AW), .DATA_W(DW), .MEM_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .ss_n(ss_n), .MOSI(MOSI), .MISO(MISO));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int nxt(input int a);
        return (a == DEPTH - 1) ? 0 : a + 1;
    endfunction

    task automatic step(input logic s, input logic d, output logic m);
        ss_n = s;
        MOSI = d;
        @(posedge clk);
        #1 m = MISO;
    endtask

    // Full frame: select edge, two command bits, ncyc payload cycles, then ss_n high.
    task automatic frame(input logic [1:0] cmd, input bq_t bits, input int ncyc, output bq_t mq);
        logic m;
        mq = {};
        step(1'b0, 1'($urandom), m);
        step(1'b0, cmd[1], m);
        step(1'b0, cmd[0], m);
        for (int i = 0; i < ncyc; i++) begin
            step(1'b0, (i < bits.size()) ? bits[i] : 1'($urandom), m);
            mq.push_back(m);
        end
        step(1'b1, 1'($urandom), m);
    endtask

    task automatic chk_quiet(input string tag, input bq_t mq);
        int ones = 0;
        foreach (mq[i]) ones += int'(mq[i]);
        chk(tag, ones, 0);
    endtask

    task automatic set_addr(input logic [1:0] cmd, input int a);
        bq_t bits, mq;
        logic [AW-1:0] av = AW'(a);
        for (int i = AW - 1; i >= 0; i--) bits.push_back(av[i]);
        frame(cmd, bits, AW + 2, mq);
        chk_quiet("addr_miso", mq);
        if (cmd == 2'b00) mdl_wa = a;
        else              mdl_ra = a;
    endtask

    // abort < 0 sends every word; otherwise ss_n rises after 'abort' data bits.
    task automatic wr_data(input wq_t words, input int abort);
        bq_t bits, mq;
        int n;
        foreach (words[w]) for (int i = DW - 1; i >= 0; i--) bits.push_back(words[w][i]);
        n = (abort < 0) ? bits.size() : abort;
        frame(2'b01, bits, n, mq);
        chk_quiet("wdata_miso", mq);
        for (int w = 0; w < n / DW; w++) begin
            if (BURST || w == 0) begin
                mdl_mem[mdl_wa] = words[w];
                if (BURST) mdl_wa = nxt(mdl_wa);
            end
        end
    endtask

    task automatic rd_data(input int nw);
        bq_t bits, mq;
        logic [DW-1:0] got, exp;
        frame(2'b11, bits, nw * (DW + 1), mq);
        for (int w = 0; w < nw; w++) begin
            int base = w * (DW + 1);
            exp = '0;
            if (BURST || w == 0) exp = mdl_mem[mdl_ra];
            if (BURST) mdl_ra = nxt(mdl_ra);
            got = '0;
            for (int b = 0; b < DW; b++) got = {got[DW-2:0], mq[base + 1 + b]};
            chk("rd_dead", 32'(mq[base]), 0);
            chk($sformatf("rd_word%0d", w), 32'(got), 32'(exp));
        end
    endtask

    initial begin
        logic m;
        wq_t ws;
        int ch;
        rst_n = 1'b0; ss_n = 1'b0; MOSI = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 1'(i), m);
            chk("rst_miso", 32'(m), 0);
        end
        rst_n = 1'b1;
        step(1'b1, 1'b0, m);

        // Give every RAM word a known value.
        ch = BURST ? 16 : 1;
        for (int a = 0; a < DEPTH; a += ch) begin
            ws = {};
            for (int k = 0; k < ch; k++) ws.push_back(DW'($urandom));
            set_addr(2'b00, a);
            wr_data(ws, -1);
        end

        // Reset with ss_n low and MOSI toggling, then read from address 0.
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 1'(~i), m);
            chk("rst2_miso", 32'(m), 0);
        end
        rst_n = 1'b1;
        mdl_wa = 0; mdl_ra = 0;
        step(1'b1, 1'b0, m);
        rd_data(1);

        set_addr(2'b00, 'h77); wr_data('{8'hAA}, -1);
        set_addr(2'b10, 'h77); rd_data(1);

        set_addr(2'b00, 'hFE); wr_data('{8'h11, 8'h22, 8'h33}, -1);
        set_addr(2'b10, 'hFE); rd_data(3);

        set_addr(2'b00, 'h10); wr_data('{8'hA5}, 5);
        set_addr(2'b10, 'h10); rd_data(1);
        wr_data('{8'h5C}, -1);
        set_addr(2'b10, 'h10); rd_data(2);

        set_addr(2'b00, 'h20); wr_data('{8'h11, 8'h22}, -1);
        set_addr(2'b10, 'h20); rd_data(2);

        // Reset during the 4th bit of a read word; no frame may start until ss_n rises.
        set_addr(2'b10, 'h40);
        step(1'b0, 1'b0, m); step(1'b0, 1'b1, m); step(1'b0, 1'b1, m);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, m);
        rst_n = 1'b0;
        step(1'b0, 1'b0, m);
        chk("rst_mid_miso", 32'(m), 0);
        rst_n = 1'b1;
        mdl_wa = 0; mdl_ra = 0;
        begin
            int ones = 0;
            for (int i = 0; i < 14; i++) begin
                step(1'b0, 1'b1, m);
                ones += int'(m);
            end
            chk("no_restart", ones, 0);
        end
        step(1'b1, 1'b0, m);
        rd_data(1);
        set_addr(2'b10, 'h40); rd_data(1);

        for (int it = 0; it < 40; it++) begin
            case ($urandom_range(0, 3))
                0: set_addr(2'b00, int'($urandom_range(0, DEPTH - 1)));
                1: begin
                    ws = {};
                    for (int k = 0; k < int'($urandom_range(1, 3)); k++) ws.push_back(DW'($urandom));
                    wr_data(ws, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, DW - 1)) : -1);
                end
                2: set_addr(2'b10, int'($urandom_range(0, DEPTH - 1)));
                default: rd_data(int'($urandom_range(1, 3)));
            endcase
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
